// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential RV32 M-extension multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mult_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mult_state_e;

  localparam int CHUNK_DEFAULT = 16;

endpackage

// File: rtl/mult_chunk_u.sv
// Combinational unsigned CHUNK x CHUNK multiplier shared by all partial products.
module mult_chunk_u #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]   a,
  input  logic [CHUNK-1:0]   b,
  output logic [2*CHUNK-1:0] p
);

  assign p = (2*CHUNK)'(a) * (2*CHUNK)'(b);

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle signed/unsigned multiplier: sign-magnitude operands, one slice
// product per cycle accumulated into a double-width register, sign fixed at the end.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mult_op_e         op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int NPP    = NSLICE * NSLICE;
  localparam int CNT_W  = (NPP > 1) ? $clog2(NPP) : 1;
  localparam int ACC_W  = 2 * WIDTH;

  mult_state_e       state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              neg_q, neg_d;
  mult_op_e          op_q, op_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic              sign_a, sign_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  int                i_idx, j_idx;
  logic [WIDTH-1:0]  a_shift, b_shift;
  logic [CHUNK-1:0]  a_slice, b_slice;
  logic [2*CHUNK-1:0] pp;
  logic [ACC_W-1:0]  pp_shift, acc_sum, full;

  // Only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
  always_comb begin
    sign_a = ((op == MULH) || (op == MULHSU)) && op_a[WIDTH-1];
    sign_b = (op == MULH) && op_b[WIDTH-1];
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;
  end

  always_comb begin
    i_idx    = int'(cnt_q) / NSLICE;
    j_idx    = int'(cnt_q) % NSLICE;
    a_shift  = a_q >> (i_idx * CHUNK);
    b_shift  = b_q >> (j_idx * CHUNK);
    a_slice  = a_shift[CHUNK-1:0];
    b_slice  = b_shift[CHUNK-1:0];
    pp_shift = ACC_W'(pp) << (CHUNK * (i_idx + j_idx));
    acc_sum  = acc_q + pp_shift;
    full     = neg_q ? -acc_sum : acc_sum;
  end

  mult_chunk_u #(.CHUNK(CHUNK)) u_chunk (
    .a (a_slice),
    .b (b_slice),
    .p (pp)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = mag_a;
          b_d     = mag_b;
          neg_d   = sign_a ^ sign_b;
          op_d    = op;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NPP - 1)) begin
          result_d = (op_q == MUL) ? full[WIDTH-1:0] : full[ACC_W-1:WIDTH];
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A kill beats everything, including a same-cycle request in IDLE.
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      op_q     <= MUL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed and randomised checks of mult_seq against hand-computed values
// and a full-width signed reference product.
module tb_mult_seq;
  import mult_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  mult_op_e    op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int testsRun;
  int testsFailed;

  mult_seq #(.WIDTH(32), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request, then waits (bounded) for out_valid; latency counts
  // clock edges from the acceptance edge up to the edge that raises out_valid.
  task automatic applyStimulus(input mult_op_e o, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output int lat);
    op       = o;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = 32'h5A5A_5A5A;
    op       = mult_op_e'(~o);
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] refMul(input mult_op_e o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [65:0] sa, sb, prod;
    logic aSigned, bSigned;
    aSigned = (o == MULH) || (o == MULHSU);
    bSigned = (o == MULH);
    sa   = aSigned ? {{34{a[31]}}, a} : {34'b0, a};
    sb   = bSigned ? {{34{b[31]}}, b} : {34'b0, b};
    prod = sa * sb;
    return (o == MUL) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] res;
  int          lat;
  int          seenValid;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    op          = MUL;
    op_a        = '0;
    op_b        = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    checkOutput("mul_m1_m1", res, 32'h0000_0001);
    checkOutput("latency", 32'(lat), 32'd5);
    applyStimulus(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    checkOutput("mulh_m1_m1", res, 32'h0000_0000);
    checkOutput("in_ready_after_done", 32'(in_ready), 32'd1);

    applyStimulus(MULH, 32'h8000_0000, 32'h8000_0000, res, lat);
    checkOutput("mulh_min_min", res, 32'h4000_0000);
    applyStimulus(MUL, 32'h8000_0000, 32'h8000_0000, res, lat);
    checkOutput("mul_min_min", res, 32'h0000_0000);

    applyStimulus(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    checkOutput("mulhu_max_max", res, 32'hFFFF_FFFE);
    applyStimulus(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    checkOutput("mulhsu_m1_max", res, 32'hFFFF_FFFF);

    // Back-pressure: result and handshake outputs must hold while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(MUL, 32'h0001_2345, 32'h0000_0010, res, lat);
    checkOutput("bp_first", res, 32'h0012_3450);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_result", result, 32'h0012_3450);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Flush wins over a same-cycle request in IDLE.
    op       = MUL;
    op_a     = 32'd3;
    op_b     = 32'd5;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_wins_in_ready", 32'(in_ready), 32'd1);

    // Flush in CALC at cnt == 2: the killed op never produces out_valid.
    op       = MULHU;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre_flush_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_keeps_result", result, 32'h0012_3450);
    seenValid = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seenValid++;
      @(posedge clk); #1;
    end
    checkOutput("flush_no_valid", 32'(seenValid), 32'd0);

    applyStimulus(MULHU, 32'h0000_FFFF, 32'h0001_0000, res, lat);
    checkOutput("post_flush_mulhu", res, 32'h0000_0000);
    checkOutput("post_flush_latency", 32'(lat), 32'd5);
    applyStimulus(MUL, 32'h0000_FFFF, 32'h0001_0000, res, lat);
    checkOutput("post_flush_mul", res, 32'hFFFF_0000);

    // One-cycle reset pulse in the middle of CALC.
    op       = MUL;
    op_a     = 32'h1234_5678;
    op_b     = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    for (int n = 0; n < 1000; n++) begin
      mult_op_e    ro;
      logic [31:0] ra, rb;
      ro = mult_op_e'($urandom_range(0, 3));
      ra = pickOperand();
      rb = pickOperand();
      applyStimulus(ro, ra, rb, res, lat);
      checkOutput($sformatf("rand_%0d_%s_%08h_%08h", n, ro.name(), ra, rb),
                  res, refMul(ro, ra, rb));
      checkOutput("rand_latency", 32'(lat), 32'd5);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
